// File: rtl/addsub_check_pkg.sv
// Shared types and constants for the add/sub checking harness: FSM states,
// operating modes, LFSR taps and the wrap-around golden model.
package addsub_check_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GSR_WAIT = 3'd1,
    S_DRIVE    = 3'd2,
    S_DRAIN    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam int MODE_ADD   = 0;
  localparam int MODE_SUB   = 1;
  localparam int MODE_MIXED = 2;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam int NUM_DIRECTED = 4;

  // Result of a +/- b truncated to width bits (no saturation).
  function automatic logic [31:0] golden(input logic [31:0] a, input logic [31:0] b,
                                         input logic sub, input int width);
    logic [31:0] sum;
    logic [31:0] mask;
    sum  = sub ? (a - b) : (a + b);
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return sum & mask;
  endfunction

endpackage

// File: rtl/exp_delay_line.sv
// Delays {valid, expected, a, b} by LATENCY cycles so each expected value
// lines up with the DUT result it belongs to; LATENCY = 0 is a wire.
module exp_delay_line #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_exp,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_exp,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b
);

  localparam int ENTRY_W = 1 + 3 * WIDTH;

  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] out_entry;

  assign in_entry = {in_valid, in_exp, in_a, in_b};
  assign {out_valid, out_exp, out_a, out_b} = out_entry;

  generate
    if (LATENCY == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clock ^ reset;
      assign out_entry = in_entry;
    end else begin : g_pipe
      logic [ENTRY_W-1:0] stage [LATENCY];
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
        end else begin
          stage[0] <= in_entry;
          for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
        end
      end
      assign out_entry = stage[LATENCY-1];
    end
  endgenerate

endmodule

// File: rtl/addsub_check_harness.sv
// Stimulus generator and checker for add/sub DUTs: waits out GSR, drives four
// corner vectors then LFSR vectors, and scores DUT results against a delayed golden value.
module addsub_check_harness
  import addsub_check_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter int          LATENCY     = 0,
  parameter int          MODE        = 0,
  parameter int          GSR_CYCLES  = 5000,
  parameter int          NUM_VECTORS = 256,
  parameter logic [31:0] SEED        = 32'hACE1_0001
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             dut_sub,
  input  logic [WIDTH-1:0] dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [31:0]      err_count,
  output logic [31:0]      chk_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH-1:0] fail_y,
  output logic [WIDTH-1:0] fail_exp,
  output state_t           fsm_state
);

  state_t           state;
  logic [31:0]      cnt;
  logic [31:0]      lfsr;
  logic [31:0]      lfsr_next;
  logic             directed;
  logic [WIDTH-1:0] drive_a;
  logic [WIDTH-1:0] drive_b;
  logic             drive_sub;
  logic             drive_valid;
  logic [WIDTH-1:0] drive_exp;
  logic             pipe_valid;
  logic [WIDTH-1:0] pipe_exp;
  logic [WIDTH-1:0] pipe_a;
  logic [WIDTH-1:0] pipe_b;

  assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
  assign directed  = cnt < 32'(NUM_DIRECTED);

  // Corner vectors first (mixed mode adds them), then the current LFSR word.
  always_comb begin
    drive_a   = '0;
    drive_b   = '0;
    drive_sub = 1'b0;
    if (state == S_DRIVE) begin
      if (directed) begin
        case (cnt[1:0])
          2'd0: begin drive_a = '0;                          drive_b = {{(WIDTH-1){1'b1}}, 1'b0}; end
          2'd1: begin drive_a = {1'b0, {(WIDTH-1){1'b1}}};   drive_b = WIDTH'(1);                 end
          2'd2: begin drive_a = {1'b1, {(WIDTH-1){1'b0}}};   drive_b = '1;                        end
          default: begin drive_a = '1;                       drive_b = '1;                        end
        endcase
        drive_sub = (MODE == MODE_SUB);
      end else begin
        drive_a   = lfsr[WIDTH-1:0];
        drive_b   = lfsr[31 -: WIDTH];
        drive_sub = (MODE == MODE_SUB) || ((MODE == MODE_MIXED) && lfsr[31]);
      end
    end
  end

  assign drive_valid = (state == S_DRIVE);
  assign drive_exp   = WIDTH'(golden(32'(drive_a), 32'(drive_b), drive_sub, WIDTH));

  assign dut_a     = drive_a;
  assign dut_b     = drive_b;
  assign dut_sub   = drive_sub;
  assign busy      = (state == S_GSR_WAIT) || (state == S_DRIVE) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  assign pass      = done && (err_count == 32'd0);
  assign fsm_state = state;

  exp_delay_line #(.WIDTH(WIDTH), .LATENCY(LATENCY)) u_delay (
    .clock    (clock),
    .reset    (reset),
    .in_valid (drive_valid),
    .in_exp   (drive_exp),
    .in_a     (drive_a),
    .in_b     (drive_b),
    .out_valid(pipe_valid),
    .out_exp  (pipe_exp),
    .out_a    (pipe_a),
    .out_b    (pipe_b)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lfsr      <= SEED;
      err_count <= '0;
      chk_count <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_y    <= '0;
      fail_exp  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_GSR_WAIT;
            cnt   <= '0;
          end
        end
        S_GSR_WAIT: begin
          if (cnt == 32'(GSR_CYCLES - 1)) begin
            state <= S_DRIVE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_DRIVE: begin
          // The LFSR word is used first, then advanced for the next vector.
          if (!directed) lfsr <= lfsr_next;
          if (cnt == 32'(NUM_VECTORS - 1)) begin
            state <= (LATENCY == 0) ? S_DONE : S_DRAIN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_DRAIN: begin
          if (cnt == 32'(LATENCY - 1)) begin
            state <= S_DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= S_DONE;
      endcase

      if (pipe_valid) begin
        chk_count <= chk_count + 32'd1;
        if (dut_y != pipe_exp) begin
          if (err_count != 32'hFFFF_FFFF) err_count <= err_count + 32'd1;
          if (err_count == 32'd0) begin
            fail_a   <= pipe_a;
            fail_b   <= pipe_b;
            fail_y   <= dut_y;
            fail_exp <= pipe_exp;
          end
        end
      end
    end
  end

endmodule

// File: doc/addsub_check_harness.md
# addsub_check_harness

Parametrised self-checking stimulus/checker for LUT- or DSP-mapped add/sub DUTs, replacing the per-width fixed-operand test mains. It holds the bench idle through global set/reset (GSR) initialisation, then drives directed corner vectors followed by LFSR vectors into a DUT of configurable width and pipeline latency. It compares every DUT result against a delayed golden model and reports pass/fail counts plus the first mismatch. It sits between the top-level clock/reset generator and the DUT inside each regression test top.

## Interface
- WIDTH, 8: operand/result width, 2..32.
- LATENCY, 0: DUT pipeline depth in cycles; 0 means a combinational DUT.
- MODE, 0: 0 = add, 1 = sub, 2 = mixed (op bit taken from LFSR bit 31).
- GSR_CYCLES, 5000: idle cycles after `start` before the first vector.
- NUM_VECTORS, 256: total vectors, including 4 directed; must be ≥ 4.
- SEED, 32'hACE1_0001: LFSR reset value; must be non-zero.
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; all state is cleared while low.
- start  in  1  level or pulse; sampled only in IDLE.
- dut_a  out  WIDTH  operand A.
- dut_b  out  WIDTH  operand B.
- dut_sub  out  1  1 = DUT computes a − b.
- dut_y  in  WIDTH  DUT result.
- busy  out  1  high in GSR_WAIT, DRIVE, DRAIN.
- done  out  1  high in DONE; sticky until reset.
- pass  out  1  done && err_count == 0.
- err_count  out  32  mismatches seen; saturates at 32'hFFFF_FFFF.
- chk_count  out  32  comparisons performed.
- fail_a, fail_b, fail_y, fail_exp  out  WIDTH each  first mismatch's A, B, DUT result and expected value.

## Operation
- FSM states: IDLE → GSR_WAIT → DRIVE → DRAIN → DONE.
- IDLE: exits to GSR_WAIT when `start` is high.
- GSR_WAIT: holds for GSR_CYCLES cycles, then enters DRIVE.
- DRIVE: issues one vector per cycle for NUM_VECTORS cycles, then enters DRAIN.
- DRAIN: lasts LATENCY cycles, then enters DONE. With LATENCY = 0, DRIVE goes directly to DONE.
- DONE: terminal state; only reset leaves it.
- Directed vectors are issued first, in this order; the op is taken from MODE (MODE 2 uses add for all four):
  - (0, −2)
  - (2^(W−1)−1, 1): signed overflow.
  - (−2^(W−1), −1)
  - (all-ones, all-ones)
- LFSR vectors follow the directed ones:
  - 32-bit Galois LFSR, taps 32'h8020_0003, advanced once per LFSR vector.
  - a = lfsr[WIDTH−1:0]; b = lfsr[31:32−WIDTH].
- Golden model: exp = (a ± b) mod 2^WIDTH, i.e. wrap-around with no saturation. Comparison is bitwise equality.
- Expected-value pipe: an expected value plus valid bit is delayed LATENCY stages.
- Compare rule: compare dut_y against the pipe output whenever the valid bit is set; each compare increments chk_count.
- Mismatch handling: err_count is incremented. The fail_* outputs are captured only on the first mismatch (err_count == 0 before the increment).
- Outside DRIVE, dut_a, dut_b and dut_sub are driven to 0. Pipe entries created outside DRIVE are invalid.
- Reset mid-run: the FSM returns to IDLE, all counters and fail_* clear to 0, the pipe valids clear, and the LFSR reloads SEED.

## Timing
- Reset values: every output is 0; the FSM is in IDLE; the LFSR holds SEED.
- `start` is sampled at edge T. The first vector is driven from T + 1 + GSR_CYCLES.
- A vector driven in cycle k is checked in cycle k + LATENCY, with the result registered at the end of that cycle.
- busy rises in the cycle after `start` is sampled. done rises, and busy falls, in the same cycle, exactly NUM_VECTORS + LATENCY cycles after DRIVE entry.
- chk_count equals NUM_VECTORS when done rises.
- `start` asserted while busy or done is ignored.

## Structure
- Package `addsub_check_pkg` holds:
  - the FSM state enum;
  - the MODE encodings;
  - the LFSR tap constant;
  - the directed-vector count (4);
  - a function `golden(a, b, sub, width)`.
- One sub-module, `exp_delay_line`: a parametrised LATENCY-deep shift register of {valid, exp, a, b}, with a pass-through when LATENCY = 0.
- The FSM, LFSR and counters live in the top module.

## Test plan
- WIDTH 8, LATENCY 0, MODE 0, ideal adder DUT. First vector must be a = 0x00, b = 0xFE, and it must check against y = 0xFE. At done, pass = 1 and chk_count = 256.
- WIDTH 8, LATENCY 2, MODE 1, registered subtractor DUT. done must rise exactly 258 cycles after DRIVE entry, with err_count = 0.
- Faulty DUT, WIDTH 8, MODE 0: bit 0 of y forced to 0.
  - Vector 2 (0x7F + 0x01 = 0x80) checks correctly. Vector 3 (0x80 + 0xFF = 0x7F) is the first mismatch and must be captured.
  - Required capture: fail_a = 0x80, fail_b = 0xFF, fail_y = 0x7E, fail_exp = 0x7F.
  - pass = 0 at done.
- GSR_CYCLES = 5000: dut_a and dut_b must stay 0 and busy must stay 1 for 5000 cycles after `start`. `start` re-pulsed during this window has no effect.
- Reset asserted mid-DRIVE at vector 100:
  - All outputs go to 0 asynchronously, before the next edge.
  - After release and a fresh `start`, the run must reproduce the identical vector sequence from SEED.
- WIDTH 32, MODE 2: the 0xFFFF_FFFF + 0x0000_0001 wrap must yield exp = 0. Mixed add/sub ops must all check correctly with an ideal DUT, giving pass = 1.
